fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the 5-stage CPU, and the producer side of the decode interface. It owns the PC, drives the synchronous instruction ROM, and presents one instruction per cycle to decode. It consumes the branch and jump signals (bne, blt, jp, jal, jr) that the control decoder raises for the instruction in the execute stage, plus the ALU compare flags. When a redirect is taken it steers the PC and squashes the wrong-path fetch. It also keeps fetch and redirect performance counters.

## Interface
Parameters:
- ADDR_W, 12, instruction address width (ROM depth 2^ADDR_W words)

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- imem_addr  out  ADDR_W  ROM read address; equals pc register
- imem_en  out  1  ROM read enable; ROM output holds when 0
- imem_data  in  32  ROM data; valid the cycle after the address is presented with imem_en=1
- stall  in  1  decode cannot accept; hold current instruction
- x_valid  in  1  execute-stage instruction is real (not a bubble)
- bne, blt, jp, jal, jr  in  1 each  control signals of the execute-stage instruction
- isNotEqual, isLessThan  in  1 each  ALU compare results for that instruction
- x_pc  in  ADDR_W  PC+1 of the execute-stage instruction
- x_imm  in  32  sign-extended 17-bit immediate
- x_target  in  27  J-type target field
- x_rd_val  in  32  register value for jr
- fd_insn  out  32  instruction to decode; equals imem_data
- fd_pc  out  ADDR_W  PC+1 of fd_insn
- fd_valid  out  1  fd_insn is a real, correct-path instruction
- redirect  out  1  combinational; a taken redirect this cycle, so downstream flushes F/D and D/X
- insn_count  out  32  instructions accepted by decode
- redirect_count  out  32  redirects taken

## Operation
- take = x_valid & (jr | jp | jal | (blt & isLessThan) | (bne & isNotEqual)).
  - redirect = take.
- Target priority, since decode guarantees at most one signal is high:
  - jr: x_rd_val[ADDR_W-1:0]
  - jp or jal: x_target[ADDR_W-1:0]
  - blt or bne: (x_pc + x_imm[ADDR_W-1:0]) mod 2^ADDR_W
- FSM with three states:
  - BOOT: entered on reset. imem_en=1. pc advances to pc+1 and fd_valid is set on the edge. Next state RUN.
  - RUN: imem_en = ~stall | take.
    - take: pc <= target, fd_valid <= 0, next state FLUSH.
    - else if ~stall: pc <= pc+1, fd_valid <= 1, fd_pc <= pc+1.
    - else all state holds.
  - FLUSH: imem_en=1 regardless of stall. pc <= pc+1, fd_pc <= pc+1, fd_valid <= 1. Next state RUN.
    - A take in FLUSH is handled as in RUN: pc <= target, fd_valid <= 0, stay in FLUSH.
- redirect beats stall on the same cycle.
- pc+1 wraps mod 2^ADDR_W; there is no fault on wrap.
- insn_count increments on every edge with fd_valid & ~stall & ~take.
- redirect_count increments on every edge with take.
- Both counters wrap at 2^32.

## Timing
- Reset values: pc=0, fd_pc=0, fd_valid=0, state=BOOT, both counters 0.
  - imem_addr=0 and imem_en=1 in the first cycle after reset.
- Reset mid-operation discards everything in flight. The next cycle behaves exactly like the first cycle after reset.
- Fetch latency: address in cycle t gives fd_insn/fd_valid in cycle t+1.
- Steady-state throughput: one instruction per cycle.
- Redirect penalty:
  - redirect in cycle t gives fd_valid=0 in cycle t+1.
  - The target instruction is valid in cycle t+2.
- Stall: fd_insn, fd_pc and fd_valid stay constant for every cycle stall is high with no take.
- take while stall is high: the stalled instruction is dropped (fd_valid=0 next cycle).

## Structure
- Shared package cpu_pkg holds:
  - opcode constants (00001 j, 00010 bne, 00011 jal, 00100 jr, 00110 blt)
  - FSM state encoding (BOOT, RUN, FLUSH)
  - instruction field widths (27-bit target, 17-bit immediate)
- One combinational sub-module, next_pc_sel: computes take and target from the execute-stage inputs.
- fetch_unit holds the registers, the FSM and the counters.

## Test plan
- Reset, no stall, ROM[i]=i:
  - fd_valid rises in cycle 1.
  - fd_insn=0,1,2,3 with fd_pc=1,2,3,4 on consecutive cycles.
  - insn_count=4 after 4 accepted instructions.
- stall high for 3 cycles while fd_pc=5: fd_pc/fd_insn hold at 5/ROM[4]. Release gives fd_pc=6 next cycle.
- bne, x_valid=1, isNotEqual=1, x_pc=10, x_imm=-4:
  - redirect=1, next cycle fd_valid=0.
  - Following cycle fd_pc=7 with fd_insn=ROM[6].
  - redirect_count=1.
- Non-taken branches:
  - blt with isLessThan=0: no redirect, sequential fetch continues.
  - bne with x_valid=0: no redirect.
- jr with x_rd_val=0x1FFF and ADDR_W=12: target 0xFFF. fd_pc wraps to 0 on that instruction.
- jal asserted together with stall, then reset asserted in the FLUSH cycle: pc=0, fd_valid=0, counters 0 next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, instruction field widths and the fetch FSM states.
package cpu_pkg;

    localparam int TARGET_W = 27;
    localparam int IMM_W    = 17;

    localparam logic [4:0] OP_J   = 5'b00001;
    localparam logic [4:0] OP_BNE = 5'b00010;
    localparam logic [4:0] OP_JAL = 5'b00011;
    localparam logic [4:0] OP_JR  = 5'b00100;
    localparam logic [4:0] OP_BLT = 5'b00110;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/next_pc_sel.sv
// Decides whether the execute-stage instruction redirects fetch, and where to.
module next_pc_sel
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic                x_valid,
    input  logic                bne,
    input  logic                blt,
    input  logic                jp,
    input  logic                jal,
    input  logic                jr,
    input  logic                isNotEqual,
    input  logic                isLessThan,
    input  logic [ADDR_W-1:0]   x_pc,
    input  logic [31:0]         x_imm,
    input  logic [TARGET_W-1:0] x_target,
    input  logic [31:0]         x_rd_val,
    output logic                take,
    output logic [ADDR_W-1:0]   target
);

    // Only the low address bits of each source matter; the rest are dropped.
    logic unused_bits;
    assign unused_bits = ^{x_imm[31:ADDR_W], x_target[TARGET_W-1:ADDR_W], x_rd_val[31:ADDR_W]};

    // Decode guarantees at most one control signal, so priority order is only a tie-break.
    always_comb begin
        take   = x_valid & (jr | jp | jal | (blt & isLessThan) | (bne & isNotEqual));
        target = x_pc + x_imm[ADDR_W-1:0];
        if (jr) begin
            target = x_rd_val[ADDR_W-1:0];
        end else if (jp | jal) begin
            target = x_target[ADDR_W-1:0];
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the instruction ROM, feeds decode.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic                clock,
    input  logic                reset,
    output logic [ADDR_W-1:0]   imem_addr,
    output logic                imem_en,
    input  logic [31:0]         imem_data,
    input  logic                stall,
    input  logic                x_valid,
    input  logic                bne,
    input  logic                blt,
    input  logic                jp,
    input  logic                jal,
    input  logic                jr,
    input  logic                isNotEqual,
    input  logic                isLessThan,
    input  logic [ADDR_W-1:0]   x_pc,
    input  logic [31:0]         x_imm,
    input  logic [TARGET_W-1:0] x_target,
    input  logic [31:0]         x_rd_val,
    output logic [31:0]         fd_insn,
    output logic [ADDR_W-1:0]   fd_pc,
    output logic                fd_valid,
    output logic                redirect,
    output logic [31:0]         insn_count,
    output logic [31:0]         redirect_count
);

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    fetch_state_t      state, state_next;
    logic [ADDR_W-1:0] pc, pc_next, pc_inc, fd_pc_next, target;
    logic              fd_valid_next, take;

    next_pc_sel #(.ADDR_W(ADDR_W)) u_next_pc_sel (
        .x_valid    (x_valid),
        .bne        (bne),
        .blt        (blt),
        .jp         (jp),
        .jal        (jal),
        .jr         (jr),
        .isNotEqual (isNotEqual),
        .isLessThan (isLessThan),
        .x_pc       (x_pc),
        .x_imm      (x_imm),
        .x_target   (x_target),
        .x_rd_val   (x_rd_val),
        .take       (take),
        .target     (target)
    );

    assign pc_inc    = pc + PC_ONE;
    assign imem_addr = pc;
    assign fd_insn   = imem_data;
    assign redirect  = take;

    // FLUSH must refetch even under stall, since the slot in decode is already a bubble.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        fd_pc_next    = fd_pc;
        fd_valid_next = fd_valid;
        imem_en       = 1'b1;
        case (state)
            BOOT: begin
                pc_next       = pc_inc;
                fd_pc_next    = pc_inc;
                fd_valid_next = 1'b1;
                state_next    = RUN;
            end
            RUN, FLUSH: begin
                imem_en = (state == FLUSH) | ~stall | take;
                if (take) begin
                    pc_next       = target;
                    fd_valid_next = 1'b0;
                    state_next    = FLUSH;
                end else if ((state == FLUSH) || !stall) begin
                    pc_next       = pc_inc;
                    fd_pc_next    = pc_inc;
                    fd_valid_next = 1'b1;
                    state_next    = RUN;
                end
            end
            default: state_next = BOOT;
        endcase
    end

    // State, PC and performance counters; reset discards everything in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= BOOT;
            pc             <= '0;
            fd_pc          <= '0;
            fd_valid       <= 1'b0;
            insn_count     <= '0;
            redirect_count <= '0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            fd_pc    <= fd_pc_next;
            fd_valid <= fd_valid_next;
            if (fd_valid & ~stall & ~take) begin
                insn_count <= insn_count + 32'd1;
            end
            if (take) begin
                redirect_count <= redirect_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then randomized traffic against a reference model.
module tb_fetch_unit;

    logic        clock, reset;
    logic [11:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_data;
    logic        stall, x_valid, bne, blt, jp, jal, jr, isNotEqual, isLessThan;
    logic [11:0] x_pc;
    logic [31:0] x_imm;
    logic [26:0] x_target;
    logic [31:0] x_rd_val;
    logic [31:0] fd_insn;
    logic [11:0] fd_pc;
    logic        fd_valid, redirect;
    logic [31:0] insn_count, redirect_count;

    logic [31:0] rom [0:4095];
    int checks = 0;
    int failures = 0;

    // Reference model: what decode should see, what was fetched, and the running counts.
    logic [11:0] m_pc, m_fd_pc;
    logic [31:0] m_insn, m_ic, m_rc;
    bit          m_fd_valid, m_boot, m_refetch;

    fetch_unit #(.ADDR_W(12)) dut (
        .clock(clock), .reset(reset), .imem_addr(imem_addr), .imem_en(imem_en),
        .imem_data(imem_data), .stall(stall), .x_valid(x_valid), .bne(bne), .blt(blt),
        .jp(jp), .jal(jal), .jr(jr), .isNotEqual(isNotEqual), .isLessThan(isLessThan),
        .x_pc(x_pc), .x_imm(x_imm), .x_target(x_target), .x_rd_val(x_rd_val),
        .fd_insn(fd_insn), .fd_pc(fd_pc), .fd_valid(fd_valid), .redirect(redirect),
        .insn_count(insn_count), .redirect_count(redirect_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (imem_en) imem_data <= rom[imem_addr];
    end

    function automatic bit model_take();
        return x_valid && (jr || jp || jal || (blt && isLessThan) || (bne && isNotEqual));
    endfunction

    function automatic logic [11:0] model_target();
        int t;
        if (jr) t = int'(x_rd_val % 4096);
        else if (jp || jal) t = int'(x_target % 4096);
        else t = (int'(x_pc) + int'(x_imm % 4096)) % 4096;
        return 12'(t);
    endfunction

    task automatic model_step();
        bit tk;
        tk = model_take();
        if (reset) begin
            m_pc = 0; m_fd_pc = 0; m_fd_valid = 0; m_boot = 1; m_refetch = 0; m_ic = 0; m_rc = 0;
            return;
        end
        if (m_fd_valid && !stall && !tk) m_ic = m_ic + 1;
        if (tk) m_rc = m_rc + 1;
        if (tk && !m_boot) begin
            m_pc = model_target(); m_fd_valid = 0; m_refetch = 1;
        end else if (m_boot || m_refetch || !stall) begin
            m_insn = rom[m_pc]; m_pc = m_pc + 12'd1; m_fd_pc = m_pc; m_fd_valid = 1; m_refetch = 0;
        end
        m_boot = 0;
    endtask

    task automatic advance();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_ctrl();
        x_valid = 0; bne = 0; blt = 0; jp = 0; jal = 0; jr = 0; isNotEqual = 0; isLessThan = 0;
        x_pc = 0; x_imm = 0; x_target = 0; x_rd_val = 0;
    endtask

    task automatic test_reset();
        reset = 1; stall = 0; clear_ctrl();
        advance(); advance();
        reset = 0;
        #1;
        checks++; if (fd_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_fd_valid got=%0b want=0", fd_valid); end
        checks++; if (fd_pc !== 12'd0) begin failures++; $display("[TB] FAIL reset_fd_pc got=%0h want=0", fd_pc); end
        checks++; if (imem_addr !== 12'd0 || imem_en !== 1'b1) begin failures++; $display("[TB] FAIL reset_imem got addr=%0h en=%0b want addr=0 en=1", imem_addr, imem_en); end
        checks++; if (insn_count !== 0 || redirect_count !== 0) begin failures++; $display("[TB] FAIL reset_counts got=%0d/%0d want=0/0", insn_count, redirect_count); end
        for (int k = 1; k <= 4; k++) begin
            advance();
            checks++;
            if (fd_valid !== 1'b1 || fd_pc !== 12'(k) || fd_insn !== rom[k-1]) begin
                failures++;
                $display("[TB] FAIL seq_fetch_%0d got v=%0b pc=%0h insn=%0h want v=1 pc=%0h insn=%0h", k, fd_valid, fd_pc, fd_insn, k, rom[k-1]);
            end
        end
        advance();
        checks++; if (insn_count !== 32'd4 || fd_pc !== 12'd5) begin failures++; $display("[TB] FAIL insn_count_4 got count=%0d pc=%0h want count=4 pc=5", insn_count, fd_pc); end
    endtask

    task automatic test_stall();
        stall = 1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (imem_en !== 1'b0) begin failures++; $display("[TB] FAIL stall_imem_en got=%0b want=0", imem_en); end
            advance();
            checks++;
            if (fd_pc !== 12'd5 || fd_insn !== rom[4] || fd_valid !== 1'b1 || insn_count !== 32'd4) begin
                failures++;
                $display("[TB] FAIL stall_hold got pc=%0h insn=%0h v=%0b cnt=%0d want pc=5 insn=%0h v=1 cnt=4", fd_pc, fd_insn, fd_valid, insn_count, rom[4]);
            end
        end
        stall = 0;
        advance();
        checks++; if (fd_pc !== 12'd6 || fd_insn !== rom[5]) begin failures++; $display("[TB] FAIL stall_release got pc=%0h insn=%0h want pc=6 insn=%0h", fd_pc, fd_insn, rom[5]); end
    endtask

    task automatic test_branch_taken();
        x_valid = 1; bne = 1; isNotEqual = 1; x_pc = 12'd10; x_imm = 32'hFFFF_FFFC;
        #1;
        checks++; if (redirect !== 1'b1) begin failures++; $display("[TB] FAIL bne_redirect got=%0b want=1", redirect); end
        advance();
        clear_ctrl();
        #1;
        checks++; if (fd_valid !== 1'b0) begin failures++; $display("[TB] FAIL bne_bubble got=%0b want=0", fd_valid); end
        advance();
        checks++;
        if (fd_valid !== 1'b1 || fd_pc !== 12'd7 || fd_insn !== rom[6] || redirect_count !== 32'd1) begin
            failures++;
            $display("[TB] FAIL bne_target got v=%0b pc=%0h insn=%0h rc=%0d want v=1 pc=7 insn=%0h rc=1", fd_valid, fd_pc, fd_insn, redirect_count, rom[6]);
        end
    endtask

    task automatic test_not_taken();
        logic [11:0] p;
        for (int k = 0; k < 2; k++) begin
            clear_ctrl();
            if (k == 0) begin x_valid = 1; blt = 1; isLessThan = 0; isNotEqual = 1; end
            else begin x_valid = 0; bne = 1; isNotEqual = 1; end
            x_pc = 12'd100; x_imm = 32'd20;
            #1;
            checks++; if (redirect !== 1'b0) begin failures++; $display("[TB] FAIL not_taken_redirect_%0d got=%0b want=0", k, redirect); end
            p = fd_pc;
            advance();
            checks++; if (fd_valid !== 1'b1 || fd_pc !== p + 12'd1) begin failures++; $display("[TB] FAIL not_taken_seq_%0d got v=%0b pc=%0h want v=1 pc=%0h", k, fd_valid, fd_pc, p + 12'd1); end
        end
        clear_ctrl();
    endtask

    task automatic test_jr_wrap();
        x_valid = 1; jr = 1; x_rd_val = 32'h0000_1FFF;
        #1;
        checks++; if (redirect !== 1'b1) begin failures++; $display("[TB] FAIL jr_redirect got=%0b want=1", redirect); end
        advance();
        clear_ctrl();
        advance();
        checks++;
        if (fd_valid !== 1'b1 || fd_pc !== 12'd0 || fd_insn !== rom[4095] || imem_addr !== 12'd0) begin
            failures++;
            $display("[TB] FAIL jr_wrap got v=%0b pc=%0h insn=%0h addr=%0h want v=1 pc=0 insn=%0h addr=0", fd_valid, fd_pc, fd_insn, imem_addr, rom[4095]);
        end
    endtask

    task automatic test_jal_stall_reset();
        stall = 1; x_valid = 1; jal = 1; x_target = 27'h123_4567;
        #1;
        checks++; if (redirect !== 1'b1 || imem_en !== 1'b1) begin failures++; $display("[TB] FAIL jal_stall got redir=%0b en=%0b want 1/1", redirect, imem_en); end
        advance();
        clear_ctrl();
        #1;
        checks++; if (fd_valid !== 1'b0 || imem_en !== 1'b1) begin failures++; $display("[TB] FAIL flush_under_stall got v=%0b en=%0b want v=0 en=1", fd_valid, imem_en); end
        reset = 1;
        advance();
        reset = 0; stall = 0;
        #1;
        checks++;
        if (imem_addr !== 12'd0 || fd_valid !== 1'b0 || fd_pc !== 12'd0 || insn_count !== 0 || redirect_count !== 0 || imem_en !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_in_flush got addr=%0h v=%0b pc=%0h ic=%0d rc=%0d en=%0b want 0/0/0/0/0/1", imem_addr, fd_valid, fd_pc, insn_count, redirect_count, imem_en);
        end
        advance();
        checks++; if (fd_valid !== 1'b1 || fd_pc !== 12'd1 || fd_insn !== rom[0]) begin failures++; $display("[TB] FAIL reboot_first got v=%0b pc=%0h insn=%0h want v=1 pc=1 insn=%0h", fd_valid, fd_pc, fd_insn, rom[0]); end
    endtask

    task automatic test_random();
        logic [16:0] imm17;
        bit          tk;
        int          bad;
        bad = 0;
        for (int n = 0; n < 600; n++) begin
            clear_ctrl();
            reset = ($urandom_range(0, 79) == 0);
            stall = ($urandom_range(0, 9) < 3);
            x_valid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                1: bne = 1;
                2: blt = 1;
                3: jp = 1;
                4: jal = 1;
                5: jr = 1;
                default: ;
            endcase
            isNotEqual = 1'($urandom); isLessThan = 1'($urandom);
            x_pc = 12'($urandom); imm17 = 17'($urandom);
            x_imm = {{15{imm17[16]}}, imm17};
            x_target = 27'($urandom); x_rd_val = $urandom;
            #1;
            tk = model_take();
            checks++;
            if (redirect !== tk || (!reset && imem_en !== (m_boot || m_refetch || !stall || tk)) || imem_addr !== m_pc) begin
                failures++; bad++;
                if (bad < 10) $display("[TB] FAIL rand_comb_%0d got redir=%0b en=%0b addr=%0h want redir=%0b addr=%0h", n, redirect, imem_en, imem_addr, tk, m_pc);
            end
            advance();
            checks++;
            if (fd_valid !== m_fd_valid || (m_fd_valid && (fd_pc !== m_fd_pc || fd_insn !== m_insn)) ||
                insn_count !== m_ic || redirect_count !== m_rc) begin
                failures++; bad++;
                if (bad < 10) $display("[TB] FAIL rand_state_%0d got v=%0b pc=%0h insn=%0h ic=%0d rc=%0d want v=%0b pc=%0h insn=%0h ic=%0d rc=%0d",
                    n, fd_valid, fd_pc, fd_insn, insn_count, redirect_count, m_fd_valid, m_fd_pc, m_insn, m_ic, m_rc);
            end
        end
        reset = 0; stall = 0; clear_ctrl();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 32'hC300_0000 | i;
        imem_data = 32'd0;
        m_pc = 0; m_fd_pc = 0; m_insn = 0; m_ic = 0; m_rc = 0;
        m_fd_valid = 0; m_boot = 1; m_refetch = 0;
        test_reset();
        test_stall();
        test_branch_taken();
        test_not_taken();
        test_jr_wrap();
        test_jal_stall_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
